// File: rtl/fx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fx_pkg
//  Description : Shared constants for the fixed-point multiply arbiter:
//                requester count, word width, fractional shift, saturation
//                limits and requester id width.
//  Revision    : 1.0  initial release
// ============================================================================
package fx_pkg;

  // Number of requesting effects (fixed at 4 in this revision)
  localparam int N_REQ = 4;

  // Signed sample / coefficient width
  localparam int DW = 16;

  // Fractional bits removed from the full-width product (Q1.15)
  localparam int FRAC = 15;

  // Width of a requester index
  localparam int ID_W = $clog2(N_REQ);

  // Saturation limits of a DW-bit signed result
  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin selector over an eligibility vector. Produces a
//                combinational one-hot grant plus its index; the priority
//                pointer moves to the requester after the winner only when a
//                grant is issued.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
  import fx_pkg::*;
#(
  parameter int N_REQ_P = fx_pkg::N_REQ,
  parameter int ID_W_P  = fx_pkg::ID_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [N_REQ_P-1:0]  i_eligible,
  output logic [N_REQ_P-1:0]  o_grant,
  output logic [ID_W_P-1:0]   o_grant_id,
  output logic                o_any
);

  // Index of the requester holding highest priority this cycle
  logic [ID_W_P-1:0] ptr_q;
  logic [ID_W_P-1:0] ptr_d;

  // Scan from the pointer upward, wrapping, and take the first eligible one
  always_comb begin
    logic [ID_W_P:0] idx;
    o_grant    = '0;
    o_grant_id = '0;
    o_any      = 1'b0;
    ptr_d      = ptr_q;
    idx        = '0;
    for (int i = 0; i < N_REQ_P; i++) begin
      idx = (ID_W_P+1)'(ptr_q) + (ID_W_P+1)'(i);
      if (idx >= (ID_W_P+1)'(N_REQ_P)) begin
        idx = idx - (ID_W_P+1)'(N_REQ_P);
      end
      if (!o_any && i_eligible[idx[ID_W_P-1:0]]) begin
        o_any                     = 1'b1;
        o_grant[idx[ID_W_P-1:0]]  = 1'b1;
        o_grant_id                = idx[ID_W_P-1:0];
        ptr_d = (idx[ID_W_P-1:0] == ID_W_P'(N_REQ_P-1)) ? '0
                                                        : idx[ID_W_P-1:0] + 1'b1;
      end
    end
  end

  // Priority pointer register; reset gives requester 0 first priority
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fx_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fx_mult_arbiter
//  Description : Shares one signed Q1.15 multiplier among N_REQ requesters.
//                Round-robin grant captures the winner's operands (stage 1),
//                stage 2 holds the full product, stage 3 shifts and saturates.
//                Fixed latency, one issue per cycle, never stalls.
//  Revision    : 1.0  initial release
// ============================================================================
module fx_mult_arbiter #(
  parameter int N_REQ = fx_pkg::N_REQ,
  parameter int DW    = fx_pkg::DW,
  parameter int FRAC  = fx_pkg::FRAC
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*DW-1:0]    i_a,
  input  logic [N_REQ*DW-1:0]    i_b,
  output logic [N_REQ-1:0]       o_grant,
  output logic                   o_valid,
  output logic [fx_pkg::ID_W-1:0] o_id,
  output logic [DW-1:0]          o_result
);

  import fx_pkg::*;

  localparam int PW = 2 * DW;

  // Saturation bounds sign-extended to product width for direct comparison
  localparam logic signed [PW-1:0] SAT_MAX_X = PW'(SAT_MAX);
  localparam logic signed [PW-1:0] SAT_MIN_X = PW'(SAT_MIN);

  // Grant register (one-hot, doubles as the "just granted" mask)
  logic [N_REQ-1:0]        grant_q, grant_d;

  // Stage 1: captured operands and owner
  logic                    s1_vld_q, s1_vld_d;
  logic signed [DW-1:0]    s1_a_q, s1_a_d;
  logic signed [DW-1:0]    s1_b_q, s1_b_d;
  logic [ID_W-1:0]         s1_id_q, s1_id_d;

  // Stage 2: full-width product
  logic                    s2_vld_q, s2_vld_d;
  logic signed [PW-1:0]    s2_prod_q, s2_prod_d;
  logic [ID_W-1:0]         s2_id_q, s2_id_d;

  // Stage 3: output registers
  logic                    out_vld_q, out_vld_d;
  logic [ID_W-1:0]         out_id_q, out_id_d;
  logic [DW-1:0]           out_res_q, out_res_d;

  // Arbiter interface
  logic [N_REQ-1:0]        eligible;
  logic [N_REQ-1:0]        arb_grant;
  logic [ID_W-1:0]         arb_id;
  logic                    arb_any;

  // Capture mux and shift/saturate intermediates
  logic signed [DW-1:0]    sel_a;
  logic signed [DW-1:0]    sel_b;
  logic signed [PW-1:0]    shifted;
  logic [DW-1:0]           sat_res;

  // A requester granted last edge sits out one arbitration round
  always_comb begin
    eligible = i_req & ~grant_q;
  end

  rr_arbiter #(
    .N_REQ_P (N_REQ),
    .ID_W_P  (ID_W)
  ) u_rr_arbiter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_eligible (eligible),
    .o_grant    (arb_grant),
    .o_grant_id (arb_id),
    .o_any      (arb_any)
  );

  // Select the winning requester's operand pair from the packed buses
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_grant[k]) begin
        sel_a = i_a[k*DW +: DW];
        sel_b = i_b[k*DW +: DW];
      end
    end
  end

  // Arithmetic shift of the product, clamped to the signed output range
  always_comb begin
    shifted = s2_prod_q >>> FRAC;
    if (shifted > SAT_MAX_X) begin
      sat_res = SAT_MAX;
    end else if (shifted < SAT_MIN_X) begin
      sat_res = SAT_MIN;
    end else begin
      sat_res = shifted[DW-1:0];
    end
  end

  // Next-state for every pipeline stage; data registers hold on bubbles
  always_comb begin
    grant_d   = arb_grant;

    s1_vld_d  = arb_any;
    s1_a_d    = arb_any ? sel_a  : s1_a_q;
    s1_b_d    = arb_any ? sel_b  : s1_b_q;
    s1_id_d   = arb_any ? arb_id : s1_id_q;

    s2_vld_d  = s1_vld_q;
    s2_prod_d = s1_vld_q ? (PW'(s1_a_q) * PW'(s1_b_q)) : s2_prod_q;
    s2_id_d   = s1_vld_q ? s1_id_q : s2_id_q;

    out_vld_d = s2_vld_q;
    out_res_d = s2_vld_q ? sat_res : out_res_q;
    out_id_d  = s2_vld_q ? s2_id_q : out_id_q;
  end

  // Pipeline registers; reset discards everything in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant_q   <= '0;
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_id_q   <= '0;
      s2_vld_q  <= 1'b0;
      s2_prod_q <= '0;
      s2_id_q   <= '0;
      out_vld_q <= 1'b0;
      out_id_q  <= '0;
      out_res_q <= '0;
    end else begin
      grant_q   <= grant_d;
      s1_vld_q  <= s1_vld_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      s1_id_q   <= s1_id_d;
      s2_vld_q  <= s2_vld_d;
      s2_prod_q <= s2_prod_d;
      s2_id_q   <= s2_id_d;
      out_vld_q <= out_vld_d;
      out_id_q  <= out_id_d;
      out_res_q <= out_res_d;
    end
  end

  assign o_grant  = grant_q;
  assign o_valid  = out_vld_q;
  assign o_id     = out_id_q;
  assign o_result = out_res_q;

endmodule
`default_nettype wire

// File: tb/tb_fx_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fx_mult_arbiter
//  Description : Self-checking bench for fx_mult_arbiter: directed scenarios
//                plus randomized traffic against a queue-based reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fx_mult_arbiter;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int FRAC = 15;

  logic            i_clk   = 1'b0;
  logic            i_rst_n = 1'b0;
  logic [N-1:0]    i_req   = '0;
  logic [N*DW-1:0] i_a     = '0;
  logic [N*DW-1:0] i_b     = '0;
  logic [N-1:0]    o_grant;
  logic            o_valid;
  logic [1:0]      o_id;
  logic [DW-1:0]   o_result;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  fx_mult_arbiter #(.N_REQ(N), .DW(DW), .FRAC(FRAC)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_req    (i_req),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_grant  (o_grant),
    .o_valid  (o_valid),
    .o_id     (o_id),
    .o_result (o_result)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [1:0]  id;
    logic [15:0] res;
  } op_t;

  op_t         pend[$];
  int          cyc      = 0;
  int          m_ptr    = 0;
  logic [3:0]  m_grant  = '0;
  logic        m_valid  = 1'b0;
  logic [1:0]  m_id     = '0;
  logic [15:0] m_result = '0;

  // Q1.15 multiply: floor(a*b / 2^15), clamped to the 16-bit signed range
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    longint p;
    longint q;
    p = longint'($signed(a)) * longint'($signed(b));
    q = p >>> FRAC;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  function automatic logic [15:0] rnd_op();
    case ($urandom % 5)
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'(($urandom % 64) - 32);
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    pend.delete();
    m_ptr    = 0;
    m_grant  = '0;
    m_valid  = 1'b0;
    m_id     = '0;
    m_result = '0;
  endtask

  // One rising edge: advance the model with the inputs present at the edge
  task automatic tick();
    logic [3:0] elig;
    int         w;
    op_t        o;
    @(posedge i_clk);
    cyc++;
    if (!i_rst_n) begin
      model_reset();
    end else begin
      elig = i_req & ~m_grant;
      w = -1;
      for (int i = 0; i < N; i++) begin
        if (w < 0 && elig[(m_ptr + i) % N]) w = (m_ptr + i) % N;
      end
      m_grant = '0;
      if (w >= 0) begin
        m_grant[w] = 1'b1;
        m_ptr      = (w + 1) % N;
        o.due      = cyc + 2;
        o.id       = 2'(w);
        o.res      = ref_mul(i_a[w*DW +: DW], i_b[w*DW +: DW]);
        pend.push_back(o);
      end
      m_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        o        = pend.pop_front();
        m_valid  = 1'b1;
        m_id     = o.id;
        m_result = o.res;
      end
    end
    #1;
  endtask

  task automatic drain();
    i_req = '0;
    repeat (4) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_req = 4'b0001;
    i_a[0 +: DW] = 16'h4000;
    i_b[0 +: DW] = 16'h4000;
    repeat (2) tick();
    tests++;
    if ({o_grant, o_valid, o_id, o_result} !== 23'd0) begin
      fails++;
      $display("FAIL reset_state: got grant=%b valid=%b id=%0d result=%h, want all zero",
               o_grant, o_valid, o_id, o_result);
    end
    #3 i_rst_n = 1'b1;
  endtask

  task automatic test_single_req0();
    tick();
    tests++;
    if (o_grant !== 4'b0001 || o_valid !== 1'b0) begin
      fails++;
      $display("FAIL first_grant: got grant=%b valid=%b, want 0001 0", o_grant, o_valid);
    end
    i_req = '0;
    i_a   = {N*DW{1'b1}};
    tick();
    tick();
    tests++;
    if (o_valid !== 1'b1 || o_id !== 2'd0 || o_result !== 16'h2000) begin
      fails++;
      $display("FAIL req0_result: got valid=%b id=%0d result=%h, want 1 0 2000",
               o_valid, o_id, o_result);
    end
    tick();
    tests++;
    if (o_valid !== 1'b0 || o_id !== 2'd0 || o_result !== 16'h2000) begin
      fails++;
      $display("FAIL hold_result: got valid=%b id=%0d result=%h, want 0 0 2000",
               o_valid, o_id, o_result);
    end
  endtask

  task automatic test_sat_req2();
    drain();
    i_req = 4'b0100;
    i_a[2*DW +: DW] = 16'h8000;
    i_b[2*DW +: DW] = 16'h8000;
    tick();
    tests++;
    if (o_grant !== 4'b0100) begin
      fails++;
      $display("FAIL sat_grant: got grant=%b, want 0100", o_grant);
    end
    i_req = '0;
    i_a[2*DW +: DW] = 16'h0001;
    i_b[2*DW +: DW] = 16'h0001;
    tick();
    tick();
    tests++;
    if (o_valid !== 1'b1 || o_id !== 2'd2 || o_result !== 16'h7FFF) begin
      fails++;
      $display("FAIL sat_result: got valid=%b id=%0d result=%h, want 1 2 7fff",
               o_valid, o_id, o_result);
    end
  endtask

  task automatic test_all_req();
    i_rst_n = 1'b0;
    model_reset();
    tick();
    i_rst_n = 1'b1;
    i_req = 4'b1111;
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < N; k++) begin
        i_a[k*DW +: DW] = rnd_op();
        i_b[k*DW +: DW] = rnd_op();
      end
      tick();
      tests++;
      if (o_grant !== 4'(1 << (t % 4)) ||
          (t >= 2 && (o_valid !== 1'b1 || o_id !== 2'((t - 2) % 4)))) begin
        fails++;
        $display("FAIL all_req t=%0d: got grant=%b valid=%b id=%0d, want grant=%b",
                 t, o_grant, o_valid, o_id, 4'(1 << (t % 4)));
      end
      tests++;
      if ({o_grant, o_valid, o_id, o_result} !== {m_grant, m_valid, m_id, m_result}) begin
        fails++;
        $display("FAIL all_req_model t=%0d: got %b %b %0d %h, want %b %b %0d %h", t,
                 o_grant, o_valid, o_id, o_result, m_grant, m_valid, m_id, m_result);
      end
    end
  endtask

  task automatic test_single_held();
    drain();
    i_req = 4'b0010;
    for (int t = 0; t < 10; t++) begin
      i_a[DW +: DW] = rnd_op();
      i_b[DW +: DW] = rnd_op();
      tick();
      tests++;
      if (o_grant !== ((t % 2 == 0) ? 4'b0010 : 4'b0000) ||
          (t >= 2 && o_valid !== (t % 2 == 0))) begin
        fails++;
        $display("FAIL single_held t=%0d: got grant=%b valid=%b", t, o_grant, o_valid);
      end
      tests++;
      if ({o_grant, o_valid, o_id, o_result} !== {m_grant, m_valid, m_id, m_result}) begin
        fails++;
        $display("FAIL single_held_model t=%0d: got %b %b %0d %h, want %b %b %0d %h", t,
                 o_grant, o_valid, o_id, o_result, m_grant, m_valid, m_id, m_result);
      end
    end
  endtask

  task automatic test_reset_midflight();
    drain();
    i_req = 4'b1000;
    i_a[3*DW +: DW] = 16'h7FFF;
    i_b[3*DW +: DW] = 16'h7FFF;
    tick();
    tests++;
    if (o_grant !== 4'b1000) begin
      fails++;
      $display("FAIL mid_grant: got grant=%b, want 1000", o_grant);
    end
    i_req = '0;
    tick();
    #3 i_rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if ({o_grant, o_valid, o_id, o_result} !== 23'd0) begin
      fails++;
      $display("FAIL mid_reset_zero: got grant=%b valid=%b id=%0d result=%h, want all zero",
               o_grant, o_valid, o_id, o_result);
    end
    tick();
    i_rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      tests++;
      if (o_valid !== 1'b0 || o_result !== 16'h0000) begin
        fails++;
        $display("FAIL mid_no_valid t=%0d: got valid=%b result=%h, want 0 0000",
                 t, o_valid, o_result);
      end
    end
  endtask

  task automatic test_rr_0_3();
    i_req = 4'b1000;
    tick();
    i_req = '0;
    tick();
    i_req = 4'b1001;
    tick();
    tests++;
    if (o_grant !== 4'b0001) begin
      fails++;
      $display("FAIL rr_first: got grant=%b, want 0001", o_grant);
    end
    i_req = 4'b1000;
    tick();
    tests++;
    if (o_grant !== 4'b1000) begin
      fails++;
      $display("FAIL rr_second: got grant=%b, want 1000", o_grant);
    end
    i_req = '0;
  endtask

  task automatic test_random();
    logic [3:0] pending;
    pending = '0;
    for (int t = 0; t < 300; t++) begin
      for (int k = 0; k < N; k++) begin
        if (!pending[k] && ($urandom % 2 == 1)) begin
          pending[k] = 1'b1;
          i_a[k*DW +: DW] = rnd_op();
          i_b[k*DW +: DW] = rnd_op();
        end else if (!pending[k]) begin
          i_a[k*DW +: DW] = rnd_op();
        end
      end
      i_req = pending;
      tick();
      tests++;
      if ({o_grant, o_valid, o_id, o_result} !== {m_grant, m_valid, m_id, m_result}) begin
        fails++;
        $display("FAIL random t=%0d: got %b %b %0d %h, want %b %b %0d %h", t,
                 o_grant, o_valid, o_id, o_result, m_grant, m_valid, m_id, m_result);
      end
      for (int k = 0; k < N; k++) begin
        if (m_grant[k]) begin
          // operands may change after capture without touching the result
          i_a[k*DW +: DW] = rnd_op();
          i_b[k*DW +: DW] = rnd_op();
          if ($urandom % 2 == 1) pending[k] = 1'b0;
        end
      end
    end
    drain();
  endtask

  initial begin
    #1;
    test_reset();
    test_single_req0();
    test_sat_req2();
    test_all_req();
    test_single_held();
    test_reset_midflight();
    test_rr_0_3();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
